// File: rtl/pipe_front_regs_pkg.sv
// Shared types and defaults for the OTTER front-end pipeline registers.
// Holds the ID/EX record layout and its bubble value.
package otter_pipe_pkg;

  localparam int XLEN   = 32;
  localparam int CTRL_W = 16;

  localparam logic [XLEN-1:0] RESET_PC_DEF  = 32'h0000_0000;
  localparam logic [31:0]     NOP_INSTR_DEF = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
    logic              rw;
    logic [CTRL_W-1:0] ctrl;
    logic              valid;
  } idex_t;

  // A bubble must never write the register file or look like a real instruction.
  localparam idex_t IDEX_BUBBLE = '0;

  function automatic logic [31:0] satInc(input logic [31:0] cnt, input logic en);
    return (en && (cnt != 32'hFFFF_FFFF)) ? cnt + 32'd1 : cnt;
  endfunction

endpackage

// File: rtl/pipe_front_regs_if.sv
// Bus between the hazard/decode/execute logic and the front-end pipeline registers.
// slave = the register block, master = the surrounding core.
interface pipe_front_regs_if #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 16
);
  logic              stallF;
  logic              stallD;
  logic              flushD;
  logic              flushE;
  logic              redirE;
  logic [XLEN-1:0]   redir_pcE;
  logic [XLEN-1:0]   imem_addr;
  logic [31:0]       imem_rdata;
  logic [4:0]        rs1D;
  logic [4:0]        rs2D;
  logic [4:0]        rdD;
  logic              rwD;
  logic [CTRL_W-1:0] ctrlD;
  logic [XLEN-1:0]   pcF;
  logic [XLEN-1:0]   pcD;
  logic [31:0]       instrD;
  logic              validD;
  logic [XLEN-1:0]   pcE;
  logic [4:0]        rs1E;
  logic [4:0]        rs2E;
  logic [4:0]        rdE;
  logic              rwE;
  logic [CTRL_W-1:0] ctrlE;
  logic              validE;

  modport slave (
    input  stallF, stallD, flushD, flushE, redirE, redir_pcE, imem_rdata,
           rs1D, rs2D, rdD, rwD, ctrlD,
    output imem_addr, pcF, pcD, instrD, validD,
           pcE, rs1E, rs2E, rdE, rwE, ctrlE, validE
  );

  modport master (
    output stallF, stallD, flushD, flushE, redirE, redir_pcE, imem_rdata,
           rs1D, rs2D, rdD, rwD, ctrlD,
    input  imem_addr, pcF, pcD, instrD, validD,
           pcE, rs1E, rs2E, rdE, rwE, ctrlE, validE
  );
endinterface

// File: rtl/pipe_front_regs_skid.sv
// Instruction hold register for synchronous-read imem: keeps the word for pcD
// across D stalls, since the memory output follows pcF, not pcD.
module instr_skid
  import otter_pipe_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        kill,
  input  logic        validD,
  input  logic [31:0] rdata,
  output logic [31:0] instr,
  output logic        holdValid
);

  logic [31:0] holdInstr;

  // First stalled cycle still sees the correct word for pcD; capture it then.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      holdValid <= 1'b0;
      holdInstr <= '0;
    end else if (kill) begin
      holdValid <= 1'b0;
    end else if (stall) begin
      if (!holdValid) begin
        holdInstr <= rdata;
        holdValid <= 1'b1;
      end
    end else begin
      holdValid <= 1'b0;
    end
  end

  assign instr = !validD   ? NOP_INSTR :
                 holdValid ? holdInstr : rdata;

endmodule

// File: rtl/pipe_front_regs.sv
// PC, IF/ID and ID/EX registers of the pipelined OTTER core.
// Optional PIPE_PERF_CNT_EN adds saturating stall/redirect/bubble counters.
module pipe_front_regs
  import otter_pipe_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0]     NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic              clk,
  input  logic              rst,
  pipe_front_regs_if.slave  bus
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_flush_cnt,
  output logic [31:0]       perf_bubble_cnt
`endif
);

  logic [XLEN-1:0] pcFReg;
  logic [XLEN-1:0] pcDReg;
  logic            validDReg;
  logic            killD;
  logic            bubbleE;
  logic            holdValid;
  idex_t           idexReg;
  idex_t           idexNext;

  // A redirect squashes the D slot as well: the word arriving next cycle is wrong-path.
  assign killD   = bus.flushD | bus.redirE;
  assign bubbleE = bus.flushE | bus.redirE | !validDReg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcFReg <= RESET_PC;
    end else if (bus.redirE) begin
      pcFReg <= bus.redir_pcE;
    end else if (!bus.stallF) begin
      pcFReg <= pcFReg + XLEN'(4);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcDReg    <= '0;
      validDReg <= 1'b0;
    end else if (killD) begin
      validDReg <= 1'b0;
    end else if (!bus.stallD) begin
      pcDReg    <= pcFReg;
      validDReg <= 1'b1;
    end
  end

  instr_skid #(
    .NOP_INSTR (NOP_INSTR)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .stall     (bus.stallD),
    .kill      (killD),
    .validD    (validDReg),
    .rdata     (bus.imem_rdata),
    .instr     (bus.instrD),
    .holdValid (holdValid)
  );

  always_comb begin
    idexNext = IDEX_BUBBLE;
    if (!bubbleE) begin
      idexNext.pc    = pcDReg;
      idexNext.rs1   = bus.rs1D;
      idexNext.rs2   = bus.rs2D;
      idexNext.rd    = bus.rdD;
      idexNext.rw    = bus.rwD;
      idexNext.ctrl  = bus.ctrlD;
      idexNext.valid = 1'b1;
    end
  end

  // E never stalls; a load-use stall holds F/D while E takes a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idexReg <= IDEX_BUBBLE;
    end else begin
      idexReg <= idexNext;
    end
  end

  assign bus.imem_addr = pcFReg;
  assign bus.pcF       = pcFReg;
  assign bus.pcD       = pcDReg;
  assign bus.validD    = validDReg;
  assign bus.pcE       = idexReg.pc;
  assign bus.rs1E      = idexReg.rs1;
  assign bus.rs2E      = idexReg.rs2;
  assign bus.rdE       = idexReg.rd;
  assign bus.rwE       = idexReg.rw;
  assign bus.ctrlE     = idexReg.ctrl;
  assign bus.validE    = idexReg.valid;

`ifdef PIPE_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cnt  <= '0;
      perf_flush_cnt  <= '0;
      perf_bubble_cnt <= '0;
    end else begin
      perf_stall_cnt  <= satInc(perf_stall_cnt, bus.stallD);
      perf_flush_cnt  <= satInc(perf_flush_cnt, bus.redirE);
      perf_bubble_cnt <= satInc(perf_bubble_cnt, bubbleE);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_front_regs.sv
// Scoreboard bench for pipe_front_regs: a cycle-level reference of the front-end
// pushes expected outputs; a negedge monitor pops and compares.
module tb_pipe_front_regs;
  import otter_pipe_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_front_regs_if #(.XLEN(XLEN), .CTRL_W(CTRL_W)) bus ();

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt, perf_bubble_cnt;
`endif

  pipe_front_regs dut (
    .clk             (clk),
    .rst             (rst),
    .bus             (bus)
`ifdef PIPE_PERF_CNT_EN
    ,
    .perf_stall_cnt  (perf_stall_cnt),
    .perf_flush_cnt  (perf_flush_cnt),
    .perf_bubble_cnt (perf_bubble_cnt)
`endif
  );

  typedef struct {
    logic [31:0] pcF;
    logic [31:0] pcD;
    logic        validD;
    logic [31:0] instrD;
    idex_t       e;
  } exp_t;

  exp_t        expQ[$];
  int          checks   = 0;
  int          failures = 0;

  // reference state
  logic [31:0] mPcF, mPcD, memAddrQ;
  logic        mValidD;
  idex_t       mE;
  int unsigned mStall, mFlush, mBubble;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    if (a == 32'h0) return 32'hAAAA_0001;
    if (a == 32'h4) return 32'hAAAA_0002;
    return {a[15:0] ^ 16'hC3A5, a[17:2]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic modelReset();
    mPcF = RESET_PC_DEF; mPcD = '0; mValidD = 1'b0; mE = IDEX_BUBBLE;
    memAddrQ = RESET_PC_DEF;
    mStall = 0; mFlush = 0; mBubble = 0;
  endtask

  task automatic pushExp();
    exp_t e;
    e.pcF    = mPcF;
    e.pcD    = mPcD;
    e.validD = mValidD;
    e.instrD = mValidD ? memWord(mPcD) : NOP_INSTR_DEF;
    e.e      = mE;
    expQ.push_back(e);
  endtask

  // One clock: drive controls, advance the reference, present next memory word.
  task automatic step(input logic sF, input logic sD, input logic fD, input logic fE,
                      input logic rE, input logic [31:0] rpc, input logic corr);
    logic bub;
    bus.stallF = sF; bus.stallD = sD; bus.flushD = fD; bus.flushE = fE;
    bus.redirE = rE; bus.redir_pcE = rpc;
    bus.rs1D = 5'($urandom); bus.rs2D = 5'($urandom); bus.rdD = 5'($urandom);
    bus.rwD = 1'($urandom); bus.ctrlD = 16'($urandom);
    @(posedge clk);
    bub = fE || rE || !mValidD;
    mE  = IDEX_BUBBLE;
    if (!bub) mE = '{pc: mPcD, rs1: bus.rs1D, rs2: bus.rs2D, rd: bus.rdD,
                     rw: bus.rwD, ctrl: bus.ctrlD, valid: 1'b1};
    memAddrQ = mPcF;
    if (fD || rE) mValidD = 1'b0;
    else if (!sD) begin mPcD = mPcF; mValidD = 1'b1; end
    if (rE) mPcF = rpc;
    else if (!sF) mPcF = mPcF + 32'd4;
    mStall += 32'(sD); mFlush += 32'(rE); mBubble += 32'(bub);
    #1;
    // Memory output is garbage whenever D is already holding its captured word.
    bus.imem_rdata = (corr && sD && !fD && !rE) ? 32'hDEAD_BEEF : memWord(memAddrQ);
    pushExp();
  endtask

  task automatic randStep();
    logic sF, sD;
    sF = ($urandom_range(0, 99) < 20);
    sD = ($urandom_range(0, 99) < 85) ? sF : ($urandom_range(0, 99) < 20);
    step(sF, sD, $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 15,
         $urandom_range(0, 99) < 10, {18'h0, 12'($urandom), 2'b00}, 1'($urandom));
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        chk("pcF", bus.pcF, e.pcF);
        chk("imem_addr", bus.imem_addr, e.pcF);
        chk("validD", 32'(bus.validD), 32'(e.validD));
        if (e.validD) chk("pcD", bus.pcD, e.pcD);
        chk("instrD", bus.instrD, e.instrD);
        chk("validE", 32'(bus.validE), 32'(e.e.valid));
        chk("pcE", bus.pcE, e.e.pc);
        chk("rs1E", 32'(bus.rs1E), 32'(e.e.rs1));
        chk("rs2E", 32'(bus.rs2E), 32'(e.e.rs2));
        chk("rdE", 32'(bus.rdE), 32'(e.e.rd));
        chk("rwE", 32'(bus.rwE), 32'(e.e.rw));
        chk("ctrlE", 32'(bus.ctrlE), 32'(e.e.ctrl));
      end
    end
  end

  initial begin
    rst = 1'b1;
    bus.stallF = 0; bus.stallD = 0; bus.flushD = 0; bus.flushE = 0; bus.redirE = 0;
    bus.redir_pcE = '0; bus.imem_rdata = '0;
    bus.rs1D = '0; bus.rs2D = '0; bus.rdD = '0; bus.rwD = 0; bus.ctrlD = '0;
    modelReset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    pushExp();

    step(0, 0, 0, 0, 0, 32'h0, 0);          // straight-line fetch
    step(0, 0, 0, 0, 0, 32'h0, 0);
    step(1, 1, 0, 1, 0, 32'h0, 1);          // load-use stall, memory output trashed
    step(1, 1, 0, 1, 0, 32'h0, 1);
    repeat (3) step(0, 0, 0, 0, 0, 32'h0, 0);
    step(0, 0, 0, 0, 1, 32'h100, 0);        // redirect
    repeat (3) step(0, 0, 0, 0, 0, 32'h0, 0);
    step(1, 0, 0, 0, 1, 32'h200, 0);        // redirect beats stallF
    step(1, 1, 0, 0, 0, 32'h0, 1);
    step(1, 1, 1, 0, 0, 32'h0, 1);          // flush beats stallD
    repeat (2) step(0, 0, 0, 0, 0, 32'h0, 0);
    step(0, 0, 0, 0, 1, 32'hFFFF_FFF8, 0);  // PC wrap
    repeat (4) step(0, 0, 0, 0, 0, 32'h0, 0);

    repeat (400) randStep();

    // async reset between edges while a load-use stall is holding D
    repeat (2) step(0, 0, 0, 0, 0, 32'h0, 0);
    step(1, 1, 0, 1, 0, 32'h0, 1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst pcF", bus.pcF, RESET_PC_DEF);
    chk("async_rst validD", 32'(bus.validD), 32'd0);
    chk("async_rst instrD", bus.instrD, NOP_INSTR_DEF);
    chk("async_rst validE", 32'(bus.validE), 32'd0);
    chk("async_rst pcE", bus.pcE, 32'd0);
    chk("async_rst rwE", 32'(bus.rwE), 32'd0);
    chk("async_rst rdE", 32'(bus.rdE), 32'd0);
`ifdef PIPE_PERF_CNT_EN
    chk("async_rst perf_stall", perf_stall_cnt, 32'd0);
    chk("async_rst perf_flush", perf_flush_cnt, 32'd0);
    chk("async_rst perf_bubble", perf_bubble_cnt, 32'd0);
`endif
    expQ.delete();
    modelReset();
    @(posedge clk);
    #1 rst = 1'b0;
    bus.stallF = 0; bus.stallD = 0; bus.flushE = 0;
    pushExp();

    repeat (150) randStep();

    @(negedge clk);
    #1;
`ifdef PIPE_PERF_CNT_EN
    chk("perf_stall", perf_stall_cnt, mStall);
    chk("perf_flush", perf_flush_cnt, mFlush);
    chk("perf_bubble", perf_bubble_cnt, mBubble);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_front_regs.md
Name: pipe_front_regs

Overview:
- Front-end pipeline register block for the pipelined OTTER (RV32I) core: PC register, IF/ID register and ID/EX register.
- Consumes the stall/flush controls that the hazard unit produces (stallF, stallD, flushD, flushE) and the branch/jump redirect from Execute.
- Supplies the rs1E/rs2E/rdE/rwE fields that the hazard unit and forward unit read back.
- Handles synchronous-read instruction memory: holds the fetched word across stalls and kills wrong-path fetches after a redirect.

Parameters:
- XLEN, 32, datapath/PC width
- CTRL_W, 16, width of the opaque decoded control word carried from D to E
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- NOP_INSTR, 32'h0000_0013, instruction presented in D when the D slot is invalid (addi x0,x0,0)

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- stallF  in  1  hold PC
- stallD  in  1  hold IF/ID
- flushD  in  1  invalidate IF/ID
- flushE  in  1  insert bubble into ID/EX
- redirE  in  1  taken branch/jump resolved in E
- redir_pcE  in  XLEN  redirect target
- imem_addr  out  XLEN  instruction fetch address (equals pcF)
- imem_rdata  in  32  instruction word, valid one cycle after imem_addr
- rs1D, rs2D, rdD  in  5 each  decoded register fields
- rwD  in  1  decoded regWrite
- ctrlD  in  CTRL_W  decoded control word
- pcF  out  XLEN  fetch PC
- pcD  out  XLEN  decode PC
- instrD  out  32  decode instruction
- validD  out  1  D slot valid
- pcE  out  XLEN  execute PC
- rs1E, rs2E, rdE  out  5 each  execute register fields
- rwE  out  1  execute regWrite
- ctrlE  out  CTRL_W  execute control word
- validE  out  1  E slot valid

Behaviour:
- Reset (asynchronous assert; release sampled on clk rising edge):
  - pcF=RESET_PC; validD=0; pcD=0; hold_valid=0.
  - All E outputs = 0, validE=0.
  - instrD shows NOP_INSTR.
- PC update, in priority order:
  - redirE → pcF<=redir_pcE. Redirect beats stallF.
  - else stallF → hold.
  - else pcF<=pcF+4; wraps modulo 2^XLEN.
- imem_addr = pcF combinationally. Memory latency is 1 cycle, so the word for pcD arrives in the cycle D holds it.
- IF/ID update, in priority order:
  - flushD or redirE → validD<=0. The next cycle's imem_rdata is wrong-path and is masked.
  - else stallD → hold pcD/validD.
  - else pcD<=pcF, validD<=1.
- Instruction hold (skid) register:
  - On the first cycle stallD is high with hold_valid=0: capture imem_rdata, set hold_valid=1.
  - While hold_valid=1: instrD = hold register.
  - hold_valid clears on the first non-stalled cycle, on flushD, or on redirE.
  - Once D advances, instrD = imem_rdata.
  - validD=0 → instrD = NOP_INSTR.
  - The block never relies on the memory holding its output.
- ID/EX update, in priority order:
  - flushE, redirE, or (validD=0 while advancing) → bubble: validE=0, rwE=0, rdE/rs1E/rs2E=0, ctrlE=0, pcE=0.
  - else → capture pcD, rs*D, rdD, rwD, ctrlD; validE<=1.
  - ID/EX has no stall input; E always advances.
- Simultaneous events:
  - stallD & flushD → flush wins.
  - stallF & redirE → redirect wins.
  - flushE during a load-use stall (stallF=stallD=flushE=1) → bubble in E while F/D hold.
- Reset mid-stall → all state cleared, including the hold register.

Optional Feature:
- Macro PIPE_PERF_CNT_EN.
- When defined: adds outputs perf_stall_cnt (32, counts cycles with stallD=1), perf_flush_cnt (32, counts cycles with redirE=1) and perf_bubble_cnt (32, counts cycles where validE is loaded 0). All reset to 0 and saturate at 2^32-1.
- When undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package otter_pipe_pkg holds:
  - XLEN, NOP_INSTR, RESET_PC defaults
  - typedef idex_t: packed struct of pc, rs1, rs2, rd, rw, ctrl, valid
  - a bubble constant of type idex_t
- One sub-module, instr_skid: the imem_rdata hold register plus hold_valid logic.

Test Plan:
- Reset: rst=1 for 3 cycles then release → pcF=0, validD=0, validE=0, instrD=0x00000013; pcF=4 on the first edge after release.
- Straight-line fetch: imem returns 0xAAAA0001 at 0 and 0xAAAA0002 at 4 → pcD=0 with instrD=0xAAAA0001, then pcE=0 with validE=1 and pcD=4 with instrD=0xAAAA0002.
- Load-use stall: stallF=stallD=flushE=1 for 2 cycles while memory output is deliberately changed to 0xDEADBEEF → pcF/pcD held, instrD keeps the captured word, validE=0 and rwE=0 both cycles; resumes cleanly afterwards.
- Redirect: redirE=1, redir_pcE=0x100 → pcF=0x100 next cycle; wrong-path word is masked (validD=0, instrD=NOP); validE=0 one cycle later; 0x100 reaches E two cycles after that.
- Simultaneous stallF=1 and redirE=1 → pcF=redir_pcE. Simultaneous stallD=1 and flushD=1 → validD=0 and hold_valid cleared.
- Async reset asserted mid-stall, between clock edges → outputs reach reset values immediately, without a clock edge; with PIPE_PERF_CNT_EN defined, counters read 0.
